stack_controller: RTL and testbench

Sequencer that executes stack operations (PUSH, POP, CALL, RET) for the CTI-8 control unit. It drives the stack pointer counter's `en`/`dir` strobes and issues byte reads and writes to the stack RAM page using the counter's `addrOut`. The stack grows downward from 0xFF. Underflow and overflow are detected from the live SP value, so a software reload of SP never leaves the controller out of step.

---
 rtl/cti8_pkg.sv | 48 ++++
 rtl/stack_controller.sv | 193 +++++++++++++++++++
 tb/tb_stack_controller.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cti8_pkg.sv
// ---------------------------------------------------------------------------
// cti8_pkg
// Shared types and constants for the CTI-8 control unit.
//   stack_op_t  : request opcode carried on req_op (PUSH/POP/CALL/RET)
//   stk_state_t : sequencing states of stack_controller
//   SP_TOP      : stack pointer value of an empty stack (stack grows down)
//   stackFault  : acceptance-time overflow/underflow test for one opcode
// ---------------------------------------------------------------------------
package cti8_pkg;

  localparam logic [7:0] SP_TOP = 8'hFF;

  typedef enum logic [1:0] {
    PUSH = 2'd0,
    POP  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } stack_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    INC  = 3'd2,
    RD   = 3'd3,
    CAP  = 3'd4,
    DONE = 3'd5
  } stk_state_t;

  // Returns 1 when the operation cannot run at the given SP. Writers need
  // room below SP (address 0x00 is never written, so SP itself must be at
  // least the number of bytes to write); readers need that many bytes
  // already on the stack, i.e. a large enough depth above SP.
  function automatic logic stackFault(input stack_op_t op, input logic [7:0] sp);
    logic [7:0] depth;
    logic       fault;
    depth = SP_TOP - sp;
    fault = 1'b0;
    case (op)
      PUSH:    fault = (sp < 8'd1);
      CALL:    fault = (sp < 8'd2);
      POP:     fault = (depth < 8'd1);
      RET:     fault = (depth < 8'd2);
      default: fault = 1'b0;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/stack_controller.sv
// ---------------------------------------------------------------------------
// stack_controller
// Sequences PUSH/POP/CALL/RET against the stack RAM page. SP itself lives in
// the external Counter; this block only steps it through sp_en/sp_dir and
// reads its live value on sp_addr, so a software reload of SP is always
// honoured by the next request.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   clk_en                global enable; FSM and all strobes gated by it
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op, req_data      opcode and payload (PUSH: [7:0], CALL: [15:0])
//   rsp_valid             high while in DONE
//   rsp_data, rsp_err     popped data / return address, error flag
//   sp_addr               current SP from the Counter
//   sp_en, sp_dir         Counter step strobe, dir=1 decrements
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata  stack RAM port, read data one clock after address
// ---------------------------------------------------------------------------
module stack_controller
  import cti8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_data,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic [7:0]  sp_addr,
  output logic        sp_en,
  output logic        sp_dir,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  stk_state_t  state;
  stk_state_t  nextState;
  stack_op_t   opReg;
  stack_op_t   reqOp;
  logic        byteIdx;
  logic [15:0] dataReg;
  logic [15:0] rspDataReg;
  logic        rspErrReg;
  logic        reqFault;
  logic        strobeOk;

  assign reqOp    = stack_op_t'(req_op);
  assign reqFault = stackFault(reqOp, sp_addr);

  // Strobes are also dropped while reset is held, so a reset landing in the
  // middle of a CALL/RET stops the in-flight write/step on that very edge.
  assign strobeOk = clk_en & rst_n;

  assign rsp_data = rspDataReg;
  assign rsp_err  = rspErrReg;

  // State register. Reset wins over the clock enable so the controller can
  // always be brought back to IDLE; otherwise it only moves on enabled edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= nextState;
    end
  end

  // Next-state logic. A faulting request skips straight to DONE. Writers
  // (PUSH/CALL) go through WR once per byte; readers (POP/RET) walk
  // INC -> RD -> CAP once per byte. byteIdx tells whether the second byte
  // of a 16-bit CALL/RET is the one being handled.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (reqFault) begin
            nextState = DONE;
          end else if (reqOp == PUSH || reqOp == CALL) begin
            nextState = WR;
          end else begin
            nextState = INC;
          end
        end
      end
      WR: begin
        if (opReg == PUSH || byteIdx) begin
          nextState = DONE;
        end
      end
      INC: nextState = RD;
      RD:  nextState = CAP;
      CAP: begin
        if (opReg == POP || byteIdx) begin
          nextState = DONE;
        end else begin
          nextState = INC;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode. In WR the byte goes to the old SP and the Counter
  // decrements on the same edge. CALL writes the high byte first so the low
  // byte ends up at the lower address, where RET finds it first. In RD and
  // CAP the address is simply the already-incremented SP, which does not
  // move again until the next INC, so it stays put across disabled cycles.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    sp_en     = 1'b0;
    sp_dir    = 1'b0;
    mem_addr  = 8'h00;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (state)
      IDLE: req_ready = 1'b1;
      WR: begin
        mem_addr = sp_addr;
        mem_we   = strobeOk;
        sp_en    = strobeOk;
        sp_dir   = 1'b1;
        if (opReg == CALL && !byteIdx) begin
          mem_wdata = dataReg[15:8];
        end else begin
          mem_wdata = dataReg[7:0];
        end
      end
      INC: begin
        sp_en  = strobeOk;
        sp_dir = 1'b0;
      end
      RD:   mem_addr = sp_addr;
      CAP:  mem_addr = sp_addr;
      DONE: rsp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Request capture and response assembly. The opcode, payload and error
  // flag are latched on the accept edge and the response is cleared, so
  // PUSH, CALL and errors report zero data. CAP latches the RAM byte: POP
  // zero-extends it, RET fills the low byte first and then the high byte.
  // Nothing here moves on a disabled edge, which keeps rsp_* stable while
  // DONE is stretched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opReg      <= PUSH;
      byteIdx    <= 1'b0;
      dataReg    <= 16'h0000;
      rspDataReg <= 16'h0000;
      rspErrReg  <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            opReg      <= reqOp;
            dataReg    <= req_data;
            byteIdx    <= 1'b0;
            rspDataReg <= 16'h0000;
            rspErrReg  <= reqFault;
          end
        end
        WR: begin
          byteIdx <= ~byteIdx;
        end
        CAP: begin
          if (opReg == POP) begin
            rspDataReg <= {8'h00, mem_rdata};
          end else if (!byteIdx) begin
            rspDataReg[7:0] <= mem_rdata;
          end else begin
            rspDataReg[15:8] <= mem_rdata;
          end
          byteIdx <= ~byteIdx;
        end
        default: begin
          byteIdx <= byteIdx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// ---------------------------------------------------------------------------
// tb_stack_controller
// Directed bench for stack_controller. The bench models the SP Counter
// (with a software reload port) and a synchronous-read stack RAM, and counts
// write/step strobes so each scenario can check exactly how many happened.
// ---------------------------------------------------------------------------
module tb_stack_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  sp_addr;
  logic        sp_en;
  logic        sp_dir;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  memArr [256];
  logic        spLoad;
  logic [7:0]  spLoadVal;
  int          writeCount = 0;
  int          stepCount = 0;
  int          violations = 0;
  int          checks = 0;
  int          fails = 0;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_CALL = 2'd2;
  localparam logic [1:0] OP_RET  = 2'd3;

  always #5 clk = ~clk;

  stack_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .sp_addr   (sp_addr),
    .sp_en     (sp_en),
    .sp_dir    (sp_dir),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // SP Counter model: software reload has priority over a step.
  always @(posedge clk) begin
    if (spLoad) begin
      sp_addr <= spLoadVal;
    end else if (sp_en) begin
      sp_addr <= sp_dir ? sp_addr - 8'd1 : sp_addr + 8'd1;
    end
  end

  // Stack RAM model with registered read data, plus strobe bookkeeping.
  always @(posedge clk) begin
    if (mem_we) begin
      memArr[mem_addr] <= mem_wdata;
    end
    mem_rdata <= memArr[mem_addr];
    if (mem_we) writeCount <= writeCount + 1;
    if (sp_en) stepCount <= stepCount + 1;
    if (!clk_en && (sp_en || mem_we)) violations <= violations + 1;
  end

  task automatic loadSp(input logic [7:0] value);
    @(negedge clk);
    spLoad = 1'b1;
    spLoadVal = value;
    @(negedge clk);
    spLoad = 1'b0;
  endtask

  // Presents one request and waits (bounded) for DONE. Latency counts the
  // accept edge plus every later enabled edge up to DONE.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] data,
                               input bit toggleEn, output int enCycles,
                               output int clocks, output logic [15:0] dataOut,
                               output logic errOut, output bit done);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_data = data;
    clk_en = 1'b1;
    enCycles = 0;
    clocks = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      clocks++;
      if (clk_en) enCycles++;
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) done = 1'b1;
      else if (toggleEn) clk_en = ~clk_en;
    end
    dataOut = rsp_data;
    errOut = rsp_err;
  endtask

  task automatic finishOp();
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input bit done, input int lat,
                             input int expLat, input logic [15:0] data,
                             input logic [15:0] expData, input logic err,
                             input logic expErr);
    checks++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL %s_timeout: no rsp_valid within bound", name);
    end
    checks++;
    if (lat !== expLat) begin
      fails++;
      $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, expLat);
    end
    checks++;
    if (data !== expData) begin
      fails++;
      $display("[TB] FAIL %s_data: got %h expected %h", name, data, expData);
    end
    checks++;
    if (err !== expErr) begin
      fails++;
      $display("[TB] FAIL %s_err: got %b expected %b", name, err, expErr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, sp_en, sp_dir, mem_we} !== 6'b100000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b expected 100000",
               {req_ready, rsp_valid, rsp_err, sp_en, sp_dir, mem_we});
    end
    checks++;
    if ({rsp_data, mem_addr, mem_wdata} !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_buses: got %h expected 0", {rsp_data, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
    loadSp(8'hFF);
  endtask

  task automatic test_push();
    int en, clks, w0;
    logic [15:0] d;
    logic e;
    bit ok;
    w0 = writeCount;
    applyStimulus(OP_PUSH, 16'h005A, 1'b0, en, clks, d, e, ok);
    checkOutput("push", ok, en, 2, d, 16'h0000, e, 1'b0);
    finishOp();
    checks++;
    if (memArr[8'hFF] !== 8'h5A || sp_addr !== 8'hFE || writeCount - w0 !== 1) begin
      fails++;
      $display("[TB] FAIL push_state: mem %h sp %h writes %0d expected 5a fe 1",
               memArr[8'hFF], sp_addr, writeCount - w0);
    end
  endtask

  task automatic test_call_ret();
    int en, clks;
    logic [15:0] d;
    logic e;
    bit ok;
    applyStimulus(OP_CALL, 16'h1234, 1'b0, en, clks, d, e, ok);
    checkOutput("call", ok, en, 3, d, 16'h0000, e, 1'b0);
    finishOp();
    checks++;
    if (memArr[8'hFE] !== 8'h12 || memArr[8'hFD] !== 8'h34 || sp_addr !== 8'hFC) begin
      fails++;
      $display("[TB] FAIL call_state: mem %h %h sp %h expected 12 34 fc",
               memArr[8'hFE], memArr[8'hFD], sp_addr);
    end
    applyStimulus(OP_RET, 16'h0000, 1'b0, en, clks, d, e, ok);
    checkOutput("ret", ok, en, 7, d, 16'h1234, e, 1'b0);
    finishOp();
    checks++;
    if (sp_addr !== 8'hFE) begin
      fails++;
      $display("[TB] FAIL ret_sp: got %h expected fe", sp_addr);
    end
  endtask

  task automatic test_pop_and_underflow();
    int en, clks, w0, s0;
    logic [15:0] d;
    logic e;
    bit ok;
    applyStimulus(OP_POP, 16'h0000, 1'b0, en, clks, d, e, ok);
    checkOutput("pop", ok, en, 4, d, 16'h005A, e, 1'b0);
    finishOp();
    checks++;
    if (sp_addr !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL pop_sp: got %h expected ff", sp_addr);
    end
    w0 = writeCount;
    s0 = stepCount;
    applyStimulus(OP_POP, 16'h0000, 1'b0, en, clks, d, e, ok);
    checkOutput("pop_underflow", ok, en, 1, d, 16'h0000, e, 1'b1);
    finishOp();
    checks++;
    if (writeCount - w0 !== 0 || stepCount - s0 !== 0 || sp_addr !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL pop_underflow_strobes: writes %0d steps %0d sp %h expected 0 0 ff",
               writeCount - w0, stepCount - s0, sp_addr);
    end
    loadSp(8'hFE);
    s0 = stepCount;
    applyStimulus(OP_RET, 16'h0000, 1'b0, en, clks, d, e, ok);
    checkOutput("ret_underflow", ok, en, 1, d, 16'h0000, e, 1'b1);
    finishOp();
    checks++;
    if (stepCount - s0 !== 0 || sp_addr !== 8'hFE) begin
      fails++;
      $display("[TB] FAIL ret_underflow_sp: steps %0d sp %h expected 0 fe",
               stepCount - s0, sp_addr);
    end
  endtask

  task automatic test_overflow();
    int en, clks, w0;
    logic [15:0] d;
    logic e;
    bit ok;
    loadSp(8'h00);
    w0 = writeCount;
    applyStimulus(OP_PUSH, 16'h00EE, 1'b0, en, clks, d, e, ok);
    checkOutput("push_overflow", ok, en, 1, d, 16'h0000, e, 1'b1);
    finishOp();
    loadSp(8'h01);
    applyStimulus(OP_CALL, 16'hBEEF, 1'b0, en, clks, d, e, ok);
    checkOutput("call_overflow", ok, en, 1, d, 16'h0000, e, 1'b1);
    finishOp();
    checks++;
    if (writeCount - w0 !== 0 || sp_addr !== 8'h01) begin
      fails++;
      $display("[TB] FAIL overflow_strobes: writes %0d sp %h expected 0 01",
               writeCount - w0, sp_addr);
    end
    applyStimulus(OP_PUSH, 16'h0077, 1'b0, en, clks, d, e, ok);
    checkOutput("push_last", ok, en, 2, d, 16'h0000, e, 1'b0);
    finishOp();
    checks++;
    if (memArr[8'h01] !== 8'h77 || sp_addr !== 8'h00) begin
      fails++;
      $display("[TB] FAIL push_last_state: mem %h sp %h expected 77 00",
               memArr[8'h01], sp_addr);
    end
  endtask

  task automatic test_clk_en_toggle();
    int en, clks, v0;
    logic [15:0] d;
    logic e;
    bit ok;
    loadSp(8'hFF);
    applyStimulus(OP_PUSH, 16'h00C3, 1'b0, en, clks, d, e, ok);
    finishOp();
    v0 = violations;
    applyStimulus(OP_POP, 16'h0000, 1'b1, en, clks, d, e, ok);
    checkOutput("pop_toggle", ok, en, 4, d, 16'h00C3, e, 1'b0);
    checks++;
    if (clks !== 7) begin
      fails++;
      $display("[TB] FAIL pop_toggle_clocks: got %0d expected 7", clks);
    end
    clk_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h00C3) begin
      fails++;
      $display("[TB] FAIL rsp_stretch: valid %b data %h expected 1 00c3", rsp_valid, rsp_data);
    end
    finishOp();
    checks++;
    if (violations - v0 !== 0 || sp_addr !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL pop_toggle_strobes: violations %0d sp %h expected 0 ff",
               violations - v0, sp_addr);
    end
  endtask

  task automatic test_reset_mid_call();
    int w0, s0;
    loadSp(8'hFF);
    w0 = writeCount;
    s0 = stepCount;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = OP_CALL;
    req_data = 16'hABCD;
    clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'hFE || mem_wdata !== 8'hCD) begin
      fails++;
      $display("[TB] FAIL second_wr: we %b addr %h data %h expected 1 fe cd",
               mem_we, mem_addr, mem_wdata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || sp_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_drop: we %b sp_en %b expected 0 0", mem_we, sp_en);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || sp_addr !== 8'hFE ||
        writeCount - w0 !== 1 || stepCount - s0 !== 1 || memArr[8'hFF] !== 8'hAB) begin
      fails++;
      $display("[TB] FAIL reset_mid_call: ready %b valid %b sp %h writes %0d steps %0d mem %h expected 1 0 fe 1 1 ab",
               req_ready, rsp_valid, sp_addr, writeCount - w0, stepCount - s0, memArr[8'hFF]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    loadSp(8'hFF);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = OP_PUSH;
    req_data = 16'h0011;
    clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_busy_ready: got %b expected 0", req_ready);
    end
    req_data = 16'h0022;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_first_done: valid %b ready %b expected 1 0", rsp_valid, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_idle_ready: got %b expected 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (rsp_valid) ok = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    checks++;
    if (!ok || memArr[8'hFF] !== 8'h11 || memArr[8'hFE] !== 8'h22 || sp_addr !== 8'hFD) begin
      fails++;
      $display("[TB] FAIL b2b_result: done %b mem %h %h sp %h expected 1 11 22 fd",
               ok, memArr[8'hFF], memArr[8'hFE], sp_addr);
    end
    finishOp();
  endtask

  initial begin
    rst_n = 1'b0;
    clk_en = 1'b1;
    req_valid = 1'b0;
    req_op = OP_PUSH;
    req_data = 16'h0000;
    spLoad = 1'b1;
    spLoadVal = 8'hFF;
    test_reset();
    test_push();
    test_call_ret();
    test_pop_and_underflow();
    test_overflow();
    test_clk_en_toggle();
    test_reset_mid_call();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
